// File: rtl/mcp_launch_mc.sv
// Launch side of a multi-channel MCP CDC transfer: per-channel hold/pend, round-robin launch, toggle handshake.
// Two edges from pass to request toggle when idle. A pass on a busy channel is dropped and flagged.
module mcp_launch_mc #(
  parameter int W           = 32,
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CW         = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            l_clk,
  input  logic            l_rst_n,
  input  logic [CH-1:0]   l_in_pass_r,
  input  logic [CH*W-1:0] l_in_r,
  output logic [CH-1:0]   l_busy_r,
  output logic [CH-1:0]   l_drop_r,
  output logic            l_ack_err_r,
  output logic [W-1:0]    sync_l_out_r,
  output logic [CW-1:0]   sync_l_out_ch_r,
  output logic            sync_l_req_tgl_r,
  input  logic            sync_c_ack_tgl
);

  typedef enum logic {IDLE = 1'b0, WAIT_ACK = 1'b1} state_t;

  state_t                 state_r, state_nxt;
  logic [W-1:0]           hold_r [CH];
  logic [CH-1:0]          pend_r;
  logic [CW-1:0]          rr_ptr;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   ack_prev;
  logic                   ack_q;
  logic                   ack_evt;
  logic                   gnt_any;
  logic [CW-1:0]          gnt_idx;
  logic                   launch;
  logic                   ack_done;
  logic                   ack_err;

  assign ack_q    = sync_ff[SYNC_STAGES-1];
  assign ack_evt  = ack_q ^ ack_prev;
  assign l_busy_r = pend_r;

  // Descending scan so the channel closest to rr_ptr wins.
  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = CH - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= CH) idx = idx - CH;
      if (pend_r[CW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = CW'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state_r;
    launch    = 1'b0;
    ack_done  = 1'b0;
    ack_err   = 1'b0;
    case (state_r)
      IDLE: begin
        ack_err = ack_evt;
        if (gnt_any) begin
          launch    = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_evt) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge l_clk) begin
    if (!l_rst_n) begin
      state_r          <= IDLE;
      pend_r           <= '0;
      rr_ptr           <= '0;
      sync_ff          <= '0;
      ack_prev         <= 1'b0;
      l_drop_r         <= '0;
      l_ack_err_r      <= 1'b0;
      sync_l_out_r     <= '0;
      sync_l_out_ch_r  <= '0;
      sync_l_req_tgl_r <= 1'b0;
      for (int i = 0; i < CH; i++) hold_r[i] <= '0;
    end else begin
      state_r     <= state_nxt;
      sync_ff     <= {sync_ff[SYNC_STAGES-2:0], sync_c_ack_tgl};
      ack_prev    <= ack_q;
      l_drop_r    <= l_in_pass_r & pend_r;
      l_ack_err_r <= ack_err;
      // Accept needs pend_r low and the ack clear needs it high, so they never collide.
      for (int i = 0; i < CH; i++) begin
        if (l_in_pass_r[i] && !pend_r[i]) begin
          hold_r[i] <= l_in_r[i*W +: W];
          pend_r[i] <= 1'b1;
        end else if (ack_done && (sync_l_out_ch_r == CW'(i))) begin
          pend_r[i] <= 1'b0;
        end
      end
      if (launch) begin
        sync_l_out_r     <= hold_r[gnt_idx];
        sync_l_out_ch_r  <= gnt_idx;
        sync_l_req_tgl_r <= ~sync_l_req_tgl_r;
        rr_ptr           <= (gnt_idx == CW'(CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule
